hack_cpu_core: RTL and testbench
================================

// Module: hack_cpu_core
// PURPOSE
// - Hack CPU datapath/control stage around the ALU: decodes the 16-bit instruction, holds the A, D and PC registers, drives the ALU control bits and consumes the ALU result and flags.
// - Produces data-memory write data, write strobe and address, and the next instruction address for the ROM.
// - Sits between instruction ROM / data RAM and the ALU: one instruction retires per clock.
// PARAMETERS
// - ADDR_W        15      width of PC and addressM (ROM/RAM address space)
// - RESET_VECTOR  15'h0   PC value loaded on reset
// PORTS
// - clk          in   1        system clock, all state updates on rising edge
// - reset        in   1        synchronous, active-high reset
// - inM          in   16       data RAM read value at addressM
// - instruction  in   16       instruction from ROM at pc
// - outM         out  16       ALU result, write data for RAM
// - writeM       out  1        RAM write strobe
// - addressM     out  ADDR_W   RAM address = A[ADDR_W-1:0]
// - pc           out  ADDR_W   address of next instruction to fetch
// BEHAVIOUR
// - One clock, reset synchronous active-high; sampled on rising edge of clk.
// - Reset: A<=0, D<=0, PC<=RESET_VECTOR; writeM forced 0 combinationally while reset=1.
// - A-instr (instruction[15]=0): A<=instruction (bit15=0); D, RAM untouched; PC<=PC+1.
// - C-instr (111a cccc ccdd djjj): a=instruction[12], c=[11:6] -> zx,nx,zy,ny,f,no of ALU.
// - ALU x=D, y = a ? inM : A (current register values, before edge).
// - Dest: [5] A<=ALU out, [4] D<=ALU out, [3] writeM=1 (combinational, same cycle).
// - outM = ALU out combinationally; only meaningful when writeM=1.
// - addressM, pc are register outputs (old A, old PC) during the cycle.
// - Jump: j1=[2] out<0 (ng), j2=[1] out==0 (zr), j3=[0] out>0 (!ng & !zr).
// - take = C-instr & ((j1&ng)|(j2&zr)|(j3&!ng&!zr)); PC <= take ? A[ADDR_W-1:0] (old A) : PC+1.
// - Jump and A-destination in same instruction: target is the pre-update A; new A visible next cycle.
// - A-instructions never jump regardless of low bits.
// - PC+1 wraps modulo 2^ADDR_W (15'h7FFF -> 15'h0000), no flag.
// - Reset dominates all other updates including jumps and stall.
// - Bits [14:13] of C-instr ignored.
// CONFIGURATION
// - CPU_STALL_EN defined: adds input 'stall' (1 bit, after instruction in port list).
// - stall=1: A, D, PC hold; writeM forced 0; outM/addressM/pc still driven from held state.
// - CPU_STALL_EN undefined: no stall port; core advances every cycle.
// TESTING
// - Reset held 2 cycles -> pc=0, addressM=0, writeM=0; after release first instr fetched at 0.
// - A-instr 16'h1234 -> next cycle addressM=15'h1234, pc=1, D unchanged.
// - @5; D=A (16'hEC10); @7; D=D+A (16'hE090) -> D=12, writeM=0 throughout.
// - A=100, D=12, M=D (16'hE308) -> writeM=1, outM=12, addressM=100 in that cycle.
// - A=40, D=0, D;JEQ (16'hE302) -> pc=40; with D=1 -> pc=PC+1; 0;JMP (16'hEA87) -> pc=A.
// - PC=15'h7FFF, non-jump instr -> pc=0; reset during taken-jump cycle -> pc=0.
// - CPU_STALL_EN: stall=1 with M=D instruction -> writeM=0, pc/A/D unchanged; stall=0 resumes.

Source files
------------

// File: rtl/hack_cpu_core.sv
// Hack CPU core: instruction decode, A/D/PC registers and the embedded Hack ALU; one instruction per clock.
// Optional macro CPU_STALL_EN adds a 'stall' input that freezes A, D, PC and suppresses writeM.
module hack_cpu_core #(
  parameter int unsigned          ADDR_W       = 15,
  parameter logic [ADDR_W-1:0]    RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       inM,
  input  logic [15:0]       instruction,
`ifdef CPU_STALL_EN
  input  logic              stall,
`endif
  output logic [15:0]       outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc
);

  localparam int unsigned DATA_W = 16;

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic              stall_c;
  logic              is_c_c;
  logic              sel_m_c;
  logic              zx_c, nx_c, zy_c, ny_c, f_c, no_c;
  logic              dst_a_c, dst_d_c, dst_m_c;
  logic              j_lt_c, j_eq_c, j_gt_c;
  logic [DATA_W-1:0] x_c, y_c, xz_c, yz_c, xn_c, yn_c, fo_c, alu_c;
  logic              zr_c, ng_c, take_c;
  logic              unused_ign_c;

`ifdef CPU_STALL_EN
  assign stall_c = stall;
`else
  assign stall_c = 1'b0;
`endif

  // Instruction field decode; bits [14:13] carry no meaning
  assign is_c_c  = instruction[15];
  assign sel_m_c = instruction[12];
  assign zx_c    = instruction[11];
  assign nx_c    = instruction[10];
  assign zy_c    = instruction[9];
  assign ny_c    = instruction[8];
  assign f_c     = instruction[7];
  assign no_c    = instruction[6];
  assign dst_a_c = instruction[5];
  assign dst_d_c = instruction[4];
  assign dst_m_c = instruction[3];
  assign j_lt_c  = instruction[2];
  assign j_eq_c  = instruction[1];
  assign j_gt_c  = instruction[0];
  assign unused_ign_c = ^instruction[14:13];

  // Hack ALU: x is always D, y selects A or the RAM read value
  always_comb begin
    x_c   = d_q;
    y_c   = sel_m_c ? inM : a_q;
    xz_c  = zx_c ? '0 : x_c;
    yz_c  = zy_c ? '0 : y_c;
    xn_c  = nx_c ? ~xz_c : xz_c;
    yn_c  = ny_c ? ~yz_c : yz_c;
    fo_c  = f_c ? DATA_W'(xn_c + yn_c) : (xn_c & yn_c);
    alu_c = no_c ? ~fo_c : fo_c;
  end

  assign zr_c   = (alu_c == '0);
  assign ng_c   = alu_c[DATA_W-1];
  assign take_c = is_c_c & ((j_lt_c & ng_c) | (j_eq_c & zr_c) | (j_gt_c & ~ng_c & ~zr_c));

  // Next-state selection; a stall simply holds every register
  always_comb begin
    a_d  = a_q;
    d_d  = d_q;
    pc_d = pc_q;
    if (!stall_c) begin
      if (!is_c_c) begin
        a_d = instruction;
      end else begin
        if (dst_a_c) a_d = alu_c;
        if (dst_d_c) d_d = alu_c;
      end
      pc_d = take_c ? a_q[ADDR_W-1:0] : ADDR_W'(pc_q + ADDR_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      d_q  <= '0;
      pc_q <= RESET_VECTOR;
    end else begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

  // The write strobe and its data follow the current instruction in the same cycle
  assign outM     = alu_c;
  assign writeM   = is_c_c & dst_m_c & ~reset & ~stall_c;
  assign addressM = a_q[ADDR_W-1:0];
  assign pc       = pc_q;

endmodule

// File: tb/tb_hack_cpu_core.sv
// Bench for hack_cpu_core: table of per-cycle vectors plus hand sequences, checked through an expectation queue.
// Define CPU_STALL_EN for both files to also exercise the stall input.
module tb_hack_cpu_core;

  typedef struct {
    logic        rst;
    logic        stl;
    logic [15:0] instr;
    logic [15:0] inm;
    logic        chk_state;
    logic [14:0] pc;
    logic [14:0] addr;
    logic        wr;
    logic        chk_out;
    logic [15:0] outm;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] inm;
  logic [15:0] instr;
  logic        stall;
  logic [15:0] out_m;
  logic        write_m;
  logic [14:0] address_m;
  logic [14:0] pc;

  int   total = 0;
  int   bad   = 0;
  vec_t tbl [28];
  vec_t sb_q [$];

  always #5 clk = ~clk;

  hack_cpu_core #(.ADDR_W(15), .RESET_VECTOR(15'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .inM         (inm),
    .instruction (instr),
`ifdef CPU_STALL_EN
    .stall       (stall),
`endif
    .outM        (out_m),
    .writeM      (write_m),
    .addressM    (address_m),
    .pc          (pc)
  );

  function automatic vec_t mk(input logic rst, input logic [15:0] ins, input logic [15:0] m,
                              input logic cs, input logic [14:0] p, input logic [14:0] a,
                              input logic w, input logic co, input logic [15:0] o);
    vec_t v;
    v.rst = rst; v.stl = 1'b0; v.instr = ins; v.inm = m;
    v.chk_state = cs; v.pc = p; v.addr = a; v.wr = w; v.chk_out = co; v.outm = o;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare just before the next rising edge
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    reset = v.rst;
    stall = v.stl;
    instr = v.instr;
    inm   = v.inm;
    sb_q.push_back(v);
    #3;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_empty[%0d]: got 0 entries expected 1", idx);
    end else begin
      e = sb_q.pop_front();
      if (e.chk_state) begin
        check($sformatf("pc[%0d]", idx), 16'(pc), 16'(e.pc));
        check($sformatf("addressM[%0d]", idx), 16'(address_m), 16'(e.addr));
      end
      check($sformatf("writeM[%0d]", idx), 16'(write_m), 16'(e.wr));
      if (e.chk_out) check($sformatf("outM[%0d]", idx), out_m, e.outm);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t h;
    reset = 1'b1; stall = 1'b0; instr = '0; inm = '0;

    //            rst  instr     inM       cs  pc        addr      wr  co  outM
    tbl[0]  = mk(1'b1, 16'hE308, 16'h0000, 0, 15'h0000, 15'h0000, 0, 0, 16'h0000);
    tbl[1]  = mk(1'b1, 16'hE308, 16'h0000, 1, 15'h0000, 15'h0000, 0, 0, 16'h0000);
    tbl[2]  = mk(1'b0, 16'h1234, 16'h0000, 1, 15'h0000, 15'h0000, 0, 0, 16'h0000);
    tbl[3]  = mk(1'b0, 16'h0005, 16'h0000, 1, 15'h0001, 15'h1234, 0, 0, 16'h0000);
    tbl[4]  = mk(1'b0, 16'hEC10, 16'h0000, 1, 15'h0002, 15'h0005, 0, 1, 16'h0005);
    tbl[5]  = mk(1'b0, 16'h0007, 16'h0000, 1, 15'h0003, 15'h0005, 0, 0, 16'h0000);
    tbl[6]  = mk(1'b0, 16'hE090, 16'h0000, 1, 15'h0004, 15'h0007, 0, 1, 16'h000C);
    tbl[7]  = mk(1'b0, 16'h0064, 16'h0000, 1, 15'h0005, 15'h0007, 0, 0, 16'h0000);
    tbl[8]  = mk(1'b0, 16'hE308, 16'h5555, 1, 15'h0006, 15'h0064, 1, 1, 16'h000C);
    tbl[9]  = mk(1'b0, 16'hFC10, 16'h00AB, 1, 15'h0007, 15'h0064, 0, 1, 16'h00AB);
    tbl[10] = mk(1'b0, 16'h0028, 16'h0000, 1, 15'h0008, 15'h0064, 0, 0, 16'h0000);
    tbl[11] = mk(1'b0, 16'hEA90, 16'h0000, 1, 15'h0009, 15'h0028, 0, 1, 16'h0000);
    tbl[12] = mk(1'b0, 16'hE302, 16'h0000, 1, 15'h000A, 15'h0028, 0, 1, 16'h0000);
    tbl[13] = mk(1'b0, 16'hEFD0, 16'h0000, 1, 15'h0028, 15'h0028, 0, 1, 16'h0001);
    tbl[14] = mk(1'b0, 16'hE302, 16'h0000, 1, 15'h0029, 15'h0028, 0, 1, 16'h0001);
    tbl[15] = mk(1'b0, 16'hEA87, 16'h0000, 1, 15'h002A, 15'h0028, 0, 1, 16'h0000);
    tbl[16] = mk(1'b0, 16'h0007, 16'h0000, 1, 15'h0028, 15'h0028, 0, 0, 16'h0000);
    tbl[17] = mk(1'b0, 16'h7FFF, 16'h0000, 1, 15'h0029, 15'h0007, 0, 0, 16'h0000);
    tbl[18] = mk(1'b0, 16'hEA87, 16'h0000, 1, 15'h002A, 15'h7FFF, 0, 1, 16'h0000);
    tbl[19] = mk(1'b0, 16'h0003, 16'h0000, 1, 15'h7FFF, 15'h7FFF, 0, 0, 16'h0000);
    tbl[20] = mk(1'b0, 16'hEE90, 16'h0000, 1, 15'h0000, 15'h0003, 0, 1, 16'hFFFF);
    tbl[21] = mk(1'b0, 16'hE304, 16'h0000, 1, 15'h0001, 15'h0003, 0, 1, 16'hFFFF);
    tbl[22] = mk(1'b0, 16'hE301, 16'h0000, 1, 15'h0003, 15'h0003, 0, 1, 16'hFFFF);
    tbl[23] = mk(1'b0, 16'hEEA7, 16'h0000, 1, 15'h0004, 15'h0003, 0, 1, 16'hFFFF);
    tbl[24] = mk(1'b0, 16'h0010, 16'h0000, 1, 15'h0003, 15'h7FFF, 0, 0, 16'h0000);
    tbl[25] = mk(1'b1, 16'hEA87, 16'h0000, 1, 15'h0004, 15'h0010, 0, 1, 16'h0000);
    tbl[26] = mk(1'b0, 16'h8308, 16'h0000, 1, 15'h0000, 15'h0000, 1, 1, 16'h0000);
    tbl[27] = mk(1'b0, 16'h0000, 16'h0000, 1, 15'h0001, 15'h0000, 0, 0, 16'h0000);

    for (int i = 0; i < 28; i++) step(tbl[i], i);

    // Countdown loop: D=2, then D=D-1;JNE back to itself until D reaches zero
    step(mk(1'b0, 16'h0002, 16'h0000, 1, 15'h0002, 15'h0000, 0, 0, 16'h0000), 100);
    step(mk(1'b0, 16'hEC10, 16'h0000, 1, 15'h0003, 15'h0002, 0, 1, 16'h0002), 101);
    step(mk(1'b0, 16'h0005, 16'h0000, 1, 15'h0004, 15'h0002, 0, 0, 16'h0000), 102);
    step(mk(1'b0, 16'hE395, 16'h0000, 1, 15'h0005, 15'h0005, 0, 1, 16'h0001), 103);
    step(mk(1'b0, 16'hE395, 16'h0000, 1, 15'h0005, 15'h0005, 0, 1, 16'h0000), 104);
    step(mk(1'b0, 16'h0000, 16'h0000, 1, 15'h0006, 15'h0005, 0, 0, 16'h0000), 105);

`ifdef CPU_STALL_EN
    // Stalled cycles hold state and suppress the write strobe
    h = mk(1'b0, 16'hE308, 16'h0000, 1, 15'h0007, 15'h0000, 0, 1, 16'h0000); h.stl = 1'b1;
    step(h, 200);
    h = mk(1'b0, 16'h0055, 16'h0000, 1, 15'h0007, 15'h0000, 0, 0, 16'h0000); h.stl = 1'b1;
    step(h, 201);
    step(mk(1'b0, 16'h0055, 16'h0000, 1, 15'h0007, 15'h0000, 0, 0, 16'h0000), 202);
    h = mk(1'b0, 16'hEC10, 16'h0000, 1, 15'h0008, 15'h0055, 0, 1, 16'h0055); h.stl = 1'b1;
    step(h, 203);
    step(mk(1'b0, 16'hE308, 16'h0000, 1, 15'h0008, 15'h0055, 1, 1, 16'h0000), 204);
    step(mk(1'b0, 16'h0000, 16'h0000, 1, 15'h0009, 15'h0055, 0, 0, 16'h0000), 205);
`else
    h = mk(1'b0, 16'h0000, 16'h0000, 1, 15'h0007, 15'h0000, 0, 0, 16'h0000);
    step(h, 200);
`endif

    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
